// File: rtl/mem_select_ctrl.sv
// Registered word-line select for the bit-memory array: accepts one request at a time and
// walks it through SETUP/ACCESS/HOLD. Addresses beyond DEPTH are rejected with an error pulse.
module mem_select_ctrl #(
  parameter int ADDR_W     = 3,
  parameter int DEPTH      = 8,
  parameter int ACCESS_CYC = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [ADDR_W-1:0] i_adr,
  input  logic              i_we,
  output logic [DEPTH-1:0]  o_wl,
  output logic              o_we,
  output logic              o_re,
  output logic              o_done,
  output logic              o_err
);

  localparam int CNT_W = $clog2(ACCESS_CYC + 1);
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } stateT;

  stateT            stateR;
  logic             weR;
  logic [CNT_W-1:0] cntR;
  logic             adrOk;

  function automatic logic [DEPTH-1:0] rowSelect(input logic [ADDR_W-1:0] adr);
    logic [DEPTH-1:0] sel;
    sel = {DEPTH{1'b0}};
    for (int n = 0; n < DEPTH; n++) begin
      sel[n] = (adr == ADDR_W'(n));
    end
    return sel;
  endfunction

  // Range check widened by one bit so DEPTH == 2**ADDR_W is representable.
  assign adrOk = ({1'b0, i_adr} < DEPTH_V);

  // Request FSM; every output is a register so nothing leaks combinationally from the inputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stateR  <= IDLE;
      weR     <= 1'b0;
      cntR    <= CNT_ZERO;
      o_ready <= 1'b0;
      o_wl    <= {DEPTH{1'b0}};
      o_we    <= 1'b0;
      o_re    <= 1'b0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (stateR)
        IDLE: begin
          if (i_valid && o_ready) begin
            if (adrOk) begin
              stateR  <= SETUP;
              weR     <= i_we;
              o_wl    <= rowSelect(i_adr);
              o_ready <= 1'b0;
            end else begin
              o_err   <= 1'b1;
              o_ready <= 1'b1;
            end
          end else begin
            o_ready <= 1'b1;
          end
        end
        SETUP: begin
          stateR <= ACCESS;
          o_we   <= weR;
          o_re   <= ~weR;
          cntR   <= CNT_LOAD;
        end
        ACCESS: begin
          // cntR holds the strobe cycles still to come after the current one.
          if (cntR == CNT_ZERO) begin
            stateR <= HOLD;
            o_we   <= 1'b0;
            o_re   <= 1'b0;
            o_done <= 1'b1;
          end else begin
            cntR <= cntR - CNT_ONE;
          end
        end
        HOLD: begin
          stateR  <= IDLE;
          o_wl    <= {DEPTH{1'b0}};
          o_ready <= 1'b1;
        end
        default: begin
          stateR  <= IDLE;
          o_wl    <= {DEPTH{1'b0}};
          o_we    <= 1'b0;
          o_re    <= 1'b0;
          o_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
